// File: rtl/disc_pkg.sv
// Shared definitions for the discriminator measurement-window sequencer.
//   CNT_W    : width of each discriminator count. It must match the counter block.
//   CNT_MAX  : all-ones count value, used for overflow detection.
//   NUM_DISC : number of discriminator channels.
//   state_e  : sequencer states.
package disc_pkg;

  localparam int CNT_W    = 16;
  localparam int NUM_DISC = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    COUNT = 3'd2,
    LATCH = 3'd3,
    HOLD  = 3'd4
  } state_e;

endpackage

// File: rtl/disc_window_ctrl_if.sv
// Snapshot hand-off bus between the window sequencer and a downstream reader.
//   snap_disc1..4 : latched counts of the last completed window
//   snap_ovf      : a channel hit all-ones during the snapshotted window
//   snap_valid    : snapshot available (producer -> reader)
//   snap_ready    : reader accepts the snapshot (reader -> producer)
// The master modport is the producer side and the slave modport is the reader side.
interface disc_window_ctrl_if;
  import disc_pkg::*;

  logic [CNT_W-1:0] snap_disc1;
  logic [CNT_W-1:0] snap_disc2;
  logic [CNT_W-1:0] snap_disc3;
  logic [CNT_W-1:0] snap_disc4;
  logic             snap_ovf;
  logic             snap_valid;
  logic             snap_ready;

  modport master (
    output snap_disc1, snap_disc2, snap_disc3, snap_disc4,
    output snap_ovf, snap_valid,
    input  snap_ready
  );

  modport slave (
    input  snap_disc1, snap_disc2, snap_disc3, snap_disc4,
    input  snap_ovf, snap_valid,
    output snap_ready
  );

endinterface

// File: rtl/disc_snapshot_reg.sv
// Snapshot registers for the window sequencer.
// This module holds the four latched counts, the per-window overflow accumulator,
// the snapshot overflow flag and the valid/ready hold logic.
//   clk, rst  : clock and synchronous active-high reset
//   clr_acc   : clear the overflow accumulator (window start)
//   acc_en    : counting cycle; an all-ones count sets the accumulator
//   capture   : latch counts and overflow, and raise snap_valid
//   abort     : drop snap_valid without a transfer; the data is kept
//   count_bus : live counter values, where channel 0 is disc1
//   snap_if   : snapshot bus (producer side)
module disc_snapshot_reg
  import disc_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clr_acc,
  input  logic                           acc_en,
  input  logic                           capture,
  input  logic                           abort,
  input  logic [NUM_DISC-1:0][CNT_W-1:0] count_bus,
  disc_window_ctrl_if.master             snap_if
);

  logic [NUM_DISC-1:0][CNT_W-1:0] snap_q, snap_d;
  logic [NUM_DISC-1:0]            at_max;
  logic                           any_max;
  logic                           ovf_acc_q, ovf_acc_d;
  logic                           snap_ovf_q, snap_ovf_d;
  logic                           valid_q, valid_d;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DISC; gi++) begin : g_max
      assign at_max[gi] = (count_bus[gi] == CNT_MAX);
    end
  endgenerate

  assign any_max = |at_max;

  always_comb begin
    snap_d     = snap_q;
    ovf_acc_d  = ovf_acc_q;
    snap_ovf_d = snap_ovf_q;
    valid_d    = valid_q;

    if (clr_acc) begin
      ovf_acc_d = 1'b0;
    end else if (acc_en && any_max) begin
      ovf_acc_d = 1'b1;
    end

    if (abort) begin
      valid_d = 1'b0;
    end else if (capture) begin
      // The LATCH-cycle values are checked as well, so a count that first
      // reaches all-ones on the final increment is still flagged.
      snap_d     = count_bus;
      snap_ovf_d = ovf_acc_q | any_max;
      valid_d    = 1'b1;
    end else if (valid_q && snap_if.snap_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      snap_q     <= '0;
      ovf_acc_q  <= 1'b0;
      snap_ovf_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      snap_q     <= snap_d;
      ovf_acc_q  <= ovf_acc_d;
      snap_ovf_q <= snap_ovf_d;
      valid_q    <= valid_d;
    end
  end

  assign snap_if.snap_disc1 = snap_q[0];
  assign snap_if.snap_disc2 = snap_q[1];
  assign snap_if.snap_disc3 = snap_q[2];
  assign snap_if.snap_disc4 = snap_q[3];
  assign snap_if.snap_ovf   = snap_ovf_q;
  assign snap_if.snap_valid = valid_q;

endmodule

// File: rtl/disc_window_ctrl.sv
// Measurement-window sequencer for the four-channel discriminator counter.
// Each window follows the same steps:
//   1. Clear the counters for one cycle.
//   2. Count for window_len cycles.
//   3. Freeze the counters for one cycle and snapshot the counts.
//   4. Hold the snapshot until the reader takes it.
// In continuous mode the sequencer re-arms after every transfer.
//   clk, rst        : clock and synchronous active-high reset
//   start, stop     : one-cycle command pulses; stop has priority
//   continuous      : re-arm mode; sampled at start
//   window_len      : count cycles, where 0 acts as 1; sampled at start
//   cnt_we, cnt_rst : counter write enable and clear
//   count_disc1..4  : live counter outputs
//   busy            : high in every state except IDLE
//   snap_if         : snapshot bus (producer side)
// The count width is CNT_W from disc_pkg.
module disc_window_ctrl
  import disc_pkg::*;
#(
  parameter int WIN_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             continuous,
  input  logic [WIN_W-1:0] window_len,
  output logic             cnt_we,
  output logic             cnt_rst,
  input  logic [CNT_W-1:0] count_disc1,
  input  logic [CNT_W-1:0] count_disc2,
  input  logic [CNT_W-1:0] count_disc3,
  input  logic [CNT_W-1:0] count_disc4,
  output logic             busy,
  disc_window_ctrl_if.master snap_if
);

  state_e                         state_q, state_d;
  logic [WIN_W-1:0]               len_q, len_d;
  logic [WIN_W-1:0]               win_q, win_d;
  logic                           mode_q, mode_d;
  logic                           cnt_we_q, cnt_we_d;
  logic                           cnt_rst_q, cnt_rst_d;
  logic                           busy_q, busy_d;
  logic                           xfer;
  logic                           clr_acc, acc_en, capture;
  logic [NUM_DISC-1:0][CNT_W-1:0] count_bus;

  assign count_bus = {count_disc4, count_disc3, count_disc2, count_disc1};
  assign xfer      = snap_if.snap_valid & snap_if.snap_ready;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    mode_d  = mode_q;
    win_d   = win_q;

    if (stop) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            len_d   = (window_len == '0) ? WIN_W'(1) : window_len;
            mode_d  = continuous;
            state_d = CLEAR;
          end
        end
        CLEAR: begin
          win_d   = len_q;
          state_d = COUNT;
        end
        COUNT: begin
          // The counter is loaded with len_q and the state exits at 1,
          // so COUNT lasts exactly len_q cycles.
          win_d = win_q - 1'b1;
          if (win_q == WIN_W'(1)) begin
            state_d = LATCH;
          end
        end
        LATCH: begin
          state_d = HOLD;
        end
        HOLD: begin
          if (xfer) begin
            state_d = mode_q ? CLEAR : IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    // Outputs are registered from the next state, so they line up with state_q.
    cnt_we_d  = (state_d == CLEAR) || (state_d == COUNT);
    cnt_rst_d = (state_d == CLEAR);
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      len_q     <= '0;
      mode_q    <= 1'b0;
      win_q     <= '0;
      cnt_we_q  <= 1'b0;
      cnt_rst_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      mode_q    <= mode_d;
      win_q     <= win_d;
      cnt_we_q  <= cnt_we_d;
      cnt_rst_q <= cnt_rst_d;
      busy_q    <= busy_d;
    end
  end

  assign cnt_we  = cnt_we_q;
  assign cnt_rst = cnt_rst_q;
  assign busy    = busy_q;

  // A stop in LATCH suppresses the capture, so the previous snapshot survives.
  assign clr_acc = (state_q == CLEAR);
  assign acc_en  = (state_q == COUNT);
  assign capture = (state_q == LATCH) && !stop;

  disc_snapshot_reg u_snap (
    .clk       (clk),
    .rst       (rst),
    .clr_acc   (clr_acc),
    .acc_en    (acc_en),
    .capture   (capture),
    .abort     (stop),
    .count_bus (count_bus),
    .snap_if   (snap_if)
  );

endmodule
